multiplier_iter: RTL
====================

Name: multiplier_iter

Overview:
- Parametrised iterative multiplier. Successor to the single-width unsigned multiplier.
- Processes BITS_PER_CYCLE multiplier bits per clock using radix-2^k shift-add.
- Each request selects signed or unsigned mode.
- Sits behind the same val/rdy request/response interfaces, so existing benches and tops can swap it in.

Parameters:
- OPERAND_W, 8, width of each operand; must be at least 2.
- BITS_PER_CYCLE, 1, multiplier bits consumed per BUSY cycle; must divide OPERAND_W. Elaboration error otherwise.
- PRODUCT_W, 2*OPERAND_W, product width; fixed derived value, not overridable.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- req_val  input  1  request valid
- req_operand_a  input  OPERAND_W  multiplicand
- req_operand_b  input  OPERAND_W  multiplier
- req_signed  input  1  1 = two's-complement operands, 0 = unsigned
- req_rdy  output  1  block can accept a request
- resp_val  output  1  product valid
- resp_product  output  PRODUCT_W  product: two's-complement if signed, else unsigned
- resp_rdy  input  1  consumer accepts product

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-low.
- While rst=0: state=IDLE, resp_val=0, resp_product=0, all datapath registers 0.
- req_rdy is combinational, equal to (state==IDLE), so it reads 1 in reset.
- States:
  - IDLE: req_rdy=1. On req_val&&req_rdy, capture operands, go to BUSY.
    - Signed mode: capture |a| and |b| into OPERAND_W-bit unsigned registers; store neg = sign(a) XOR sign(b).
    - Unsigned mode: capture a and b as-is; neg = 0.
    - Clear the accumulator; iteration counter = N-1, where N = OPERAND_W/BITS_PER_CYCLE.
  - BUSY, each cycle:
    - acc += (a_mag * b_mag[BITS_PER_CYCLE-1:0]) << shift.
    - b_mag >>= BITS_PER_CYCLE; shift += BITS_PER_CYCLE.
    - When counter==0, register resp_product = neg ? -acc_next : acc_next (PRODUCT_W bits, wraps modulo 2^PRODUCT_W) and go to DONE. Otherwise decrement the counter.
  - DONE: resp_val=1, resp_product held stable. On resp_rdy, go to IDLE. resp_val drops the next cycle; resp_product keeps its last value.
- Latency: request accepted at edge 0 -> resp_val high after edge N+1 (N BUSY cycles). Throughput is one product per N+2 cycles when resp_rdy is tied high.
- No request is accepted while in BUSY or DONE. req_val held high is ignored until IDLE.
- Magnitude of the most-negative operand (e.g. -128 at width 8) is representable unsigned; the product is exact.
- Signed mode: result fits PRODUCT_W exactly; no overflow possible.
- resp_rdy high on entering DONE: product is valid for exactly one cycle, then IDLE.
- Async reset mid-BUSY or mid-DONE: the operation is discarded, no response is produced, and state returns to IDLE immediately.
- Operands, mode and the rdy inputs are sampled only in the states listed; changes at other times have no effect.

Optional Feature:
- Macro: MULTIPLIER_ITER_EARLY_TERM_EN.
- Defined: in BUSY, if the remaining b_mag (after the current shift) is 0, the result is finalised that cycle and the block goes to DONE regardless of the counter.
  - Minimum latency is 1 BUSY cycle, e.g. b=0 or b=1.
  - The result is identical to the full iteration.
- Undefined: always exactly N BUSY cycles; latency is data-independent.

Decomposition:
- Package multiplier_iter_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - localparam function computing N
  - function abs_w() returning an unsigned magnitude
- One combinational sub-module, multiplier_iter_pp: inputs a_mag and a BITS_PER_CYCLE slice of b; output is the shifted partial product for one step. Instantiated once.
- FSM and datapath registers stay in multiplier_iter.

Test Plan:
- Reset with req_val=1 held -> req_rdy=1, resp_val=0, resp_product=0; no request is accepted until rst=1, and then only on the first rising edge.
- Unsigned, OPERAND_W=8, BPC=1: a=255, b=255 -> 65025 (0xFE01) exactly 9 cycles after acceptance; req_rdy=0 throughout BUSY and DONE.
- Signed: (-128)*(-128) -> 0x4000; (-3)*5 -> 0xFFF1; 127*(-128) -> 0xC080.
- Backpressure: resp_rdy low for 5 cycles in DONE -> resp_val and resp_product stable; the new request offered meanwhile is not accepted until the cycle after the handshake.
- BPC=4, OPERAND_W=8: 200*13 -> 2600 with resp_val 3 cycles after acceptance. With MULTIPLIER_ITER_EARLY_TERM_EN, BPC=1: a=7, b=1 -> 7 after 1 BUSY cycle.
- rst asserted during the 3rd BUSY cycle -> no resp_val ever for that request; the next request after reset returns the correct product.

Source files
------------

// File: rtl/multiplier_iter_pkg.sv
// Shared state encoding and helpers for the iterative shift-add multiplier.
package multiplier_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest operand (sign-extended) that abs_w can take a magnitude of.
  localparam int ABS_W = 64;

  function automatic int num_steps(input int operand_w, input int bits_per_cycle);
    return operand_w / bits_per_cycle;
  endfunction

  function automatic logic [ABS_W-1:0] abs_w(input logic [ABS_W-1:0] value);
    logic [ABS_W-1:0] mag;
    if (value[ABS_W-1]) begin
      mag = ~value + 64'd1;
    end else begin
      mag = value;
    end
    return mag;
  endfunction

endpackage

// File: rtl/multiplier_iter_pp.sv
// One radix-2^k partial product: a_mag times a BITS_PER_CYCLE slice of b, shifted into place.
module multiplier_iter_pp
  import multiplier_iter_pkg::*;
#(
  parameter int OPERAND_W      = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter int PRODUCT_W      = 2 * OPERAND_W,
  parameter int SHIFT_W        = $clog2(OPERAND_W)
) (
  input  logic [OPERAND_W-1:0]      i_a_mag,
  input  logic [BITS_PER_CYCLE-1:0] i_b_slice,
  input  logic [SHIFT_W-1:0]        i_shift,
  output logic [PRODUCT_W-1:0]      o_pp
);

  logic [PRODUCT_W-1:0] w_step;

  assign w_step = PRODUCT_W'(i_a_mag) * PRODUCT_W'(i_b_slice);
  assign o_pp   = w_step << i_shift;

endmodule

// File: rtl/multiplier_iter.sv
// Iterative signed/unsigned multiplier behind val/rdy request and response ports.
// Optional MULTIPLIER_ITER_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module multiplier_iter
  import multiplier_iter_pkg::*;
#(
  parameter int   OPERAND_W      = 8,
  parameter int   BITS_PER_CYCLE = 1,
  localparam int  PRODUCT_W      = 2 * OPERAND_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_val,
  input  logic [OPERAND_W-1:0] req_operand_a,
  input  logic [OPERAND_W-1:0] req_operand_b,
  input  logic                 req_signed,
  output logic                 req_rdy,
  output logic                 resp_val,
  output logic [PRODUCT_W-1:0] resp_product,
  input  logic                 resp_rdy
);

  localparam int N       = num_steps(OPERAND_W, BITS_PER_CYCLE);
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
  localparam int SHIFT_W = $clog2(OPERAND_W);

  if (OPERAND_W < 2 || OPERAND_W >= ABS_W) begin : g_bad_operand_w
    $error("multiplier_iter: OPERAND_W out of range");
  end
  if (BITS_PER_CYCLE < 1 || (OPERAND_W % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
    $error("multiplier_iter: BITS_PER_CYCLE must divide OPERAND_W");
  end

  state_e                r_state;
  state_e                w_state_next;
  logic [OPERAND_W-1:0]  r_a_mag;
  logic [OPERAND_W-1:0]  r_b_mag;
  logic                  r_neg;
  logic [PRODUCT_W-1:0]  r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [SHIFT_W-1:0]    r_shift;
  logic                  r_resp_val;
  logic [PRODUCT_W-1:0]  r_product;

  logic                  w_accept;
  logic                  w_finish;
  logic                  w_release;
  logic                  w_last;
  logic [ABS_W-1:0]      w_a_ext;
  logic [ABS_W-1:0]      w_b_ext;
  logic [OPERAND_W-1:0]  w_a_abs;
  logic [OPERAND_W-1:0]  w_b_abs;
  logic [PRODUCT_W-1:0]  w_pp;
  logic [PRODUCT_W-1:0]  w_acc_next;
  logic [OPERAND_W-1:0]  w_b_next;
  logic [PRODUCT_W-1:0]  w_result;

  // Unsigned requests zero-extend, so the magnitude helper leaves them untouched.
  assign w_a_ext = {{(ABS_W-OPERAND_W){req_signed & req_operand_a[OPERAND_W-1]}}, req_operand_a};
  assign w_b_ext = {{(ABS_W-OPERAND_W){req_signed & req_operand_b[OPERAND_W-1]}}, req_operand_b};
  assign w_a_abs = OPERAND_W'(abs_w(w_a_ext));
  assign w_b_abs = OPERAND_W'(abs_w(w_b_ext));

  multiplier_iter_pp #(
    .OPERAND_W      (OPERAND_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .PRODUCT_W      (PRODUCT_W),
    .SHIFT_W        (SHIFT_W)
  ) u_pp (
    .i_a_mag   (r_a_mag),
    .i_b_slice (r_b_mag[BITS_PER_CYCLE-1:0]),
    .i_shift   (r_shift),
    .o_pp      (w_pp)
  );

  assign w_acc_next = r_acc + w_pp;
  assign w_b_next   = r_b_mag >> BITS_PER_CYCLE;
  assign w_result   = r_neg ? ({PRODUCT_W{1'b0}} - w_acc_next) : w_acc_next;

`ifdef MULTIPLIER_ITER_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_W'(0)) || (w_b_next == OPERAND_W'(0));
`else
  assign w_last = (r_cnt == CNT_W'(0));
`endif

  assign req_rdy      = (r_state == IDLE);
  assign resp_val     = r_resp_val;
  assign resp_product = r_product;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_val) begin
          w_accept     = 1'b1;
          w_state_next = BUSY;
        end else begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_finish     = 1'b1;
          w_state_next = DONE;
        end else begin
          w_state_next = BUSY;
        end
      end
      DONE: begin
        if (resp_rdy) begin
          w_release    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_state_next = DONE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand capture, shift-add iteration and registered response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_mag    <= '0;
      r_b_mag    <= '0;
      r_neg      <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_resp_val <= 1'b0;
      r_product  <= '0;
    end else begin
      if (w_accept) begin
        r_a_mag <= w_a_abs;
        r_b_mag <= w_b_abs;
        r_neg   <= req_signed & (req_operand_a[OPERAND_W-1] ^ req_operand_b[OPERAND_W-1]);
        r_acc   <= '0;
        r_cnt   <= CNT_W'(N - 1);
        r_shift <= '0;
      end else if (r_state == BUSY) begin
        r_acc   <= w_acc_next;
        r_b_mag <= w_b_next;
        r_shift <= r_shift + SHIFT_W'(BITS_PER_CYCLE);
        if (!w_last) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end
      if (w_finish) begin
        r_resp_val <= 1'b1;
        r_product  <= w_result;
      end else if (w_release) begin
        r_resp_val <= 1'b0;
      end
    end
  end

endmodule
